// File: rtl/xadac_scoreboard_pkg.sv
// Shared defaults and helpers for the xadac in-flight scoreboard.
package xadac_scoreboard_pkg;

   localparam int unsigned NO_RS_DEF          = 2;
   localparam int unsigned NO_VS_DEF          = 3;
   localparam int unsigned ID_WIDTH_DEF       = 3;
   localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
   localparam int unsigned VEC_ADDR_WIDTH_DEF = 5;

   // Number of scoreboard entries addressed by an ID of the given width.
   function automatic int unsigned sb_len(input int unsigned id_width);
      return 32'd1 << id_width;
   endfunction

endpackage

// File: rtl/xadac_scoreboard_if.sv
// Decode / retire / status bundle between the decoder side and the scoreboard.
interface xadac_scoreboard_if
   import xadac_scoreboard_pkg::*;
#(
   parameter int unsigned NoRs         = NO_RS_DEF,
   parameter int unsigned NoVs         = NO_VS_DEF,
   parameter int unsigned IdWidth      = ID_WIDTH_DEF,
   parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH_DEF,
   parameter int unsigned VecAddrWidth = VEC_ADDR_WIDTH_DEF
) ();

   logic                         flush_i;
   logic                         dec_valid_i;
   logic                         dec_ready_o;
   logic [IdWidth-1:0]           dec_id_o;
   logic [RegAddrWidth-1:0]      dec_rd_addr_i;
   logic                         dec_rd_clob_i;
   logic [VecAddrWidth-1:0]      dec_vd_addr_i;
   logic                         dec_vd_clob_i;
   logic [NoRs*RegAddrWidth-1:0] dec_rs_addr_i;
   logic [NoRs-1:0]              dec_rs_read_i;
   logic [NoVs*VecAddrWidth-1:0] dec_vs_addr_i;
   logic [NoVs-1:0]              dec_vs_read_i;
   logic                         rsp_valid_i;
   logic [IdWidth-1:0]           rsp_id_i;
   logic [IdWidth:0]             count_o;
   logic                         full_o;
   logic                         spurious_o;

   modport master (
      output flush_i, dec_valid_i, dec_rd_addr_i, dec_rd_clob_i, dec_vd_addr_i, dec_vd_clob_i,
             dec_rs_addr_i, dec_rs_read_i, dec_vs_addr_i, dec_vs_read_i, rsp_valid_i, rsp_id_i,
      input  dec_ready_o, dec_id_o, count_o, full_o, spurious_o
   );

   modport slave (
      input  flush_i, dec_valid_i, dec_rd_addr_i, dec_rd_clob_i, dec_vd_addr_i, dec_vd_clob_i,
             dec_rs_addr_i, dec_rs_read_i, dec_vs_addr_i, dec_vs_read_i, rsp_valid_i, rsp_id_i,
      output dec_ready_o, dec_id_o, count_o, full_o, spurious_o
   );

endinterface

// File: rtl/xadac_scoreboard_match.sv
// Hazard check of one outstanding entry against the current decode request.
module xadac_scoreboard_match
   import xadac_scoreboard_pkg::*;
#(
   parameter int unsigned NoRs         = NO_RS_DEF,
   parameter int unsigned NoVs         = NO_VS_DEF,
   parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH_DEF,
   parameter int unsigned VecAddrWidth = VEC_ADDR_WIDTH_DEF,
   parameter int unsigned TrackX0      = 0
) (
   input  logic                         e_valid,
   input  logic [RegAddrWidth-1:0]      e_rd_addr,
   input  logic                         e_rd_wr,
   input  logic [VecAddrWidth-1:0]      e_vd_addr,
   input  logic                         e_vd_wr,
   input  logic [RegAddrWidth-1:0]      rd_addr,
   input  logic                         rd_clob,
   input  logic [VecAddrWidth-1:0]      vd_addr,
   input  logic                         vd_clob,
   input  logic [NoRs*RegAddrWidth-1:0] rs_addr,
   input  logic [NoRs-1:0]              rs_read,
   input  logic [NoVs*VecAddrWidth-1:0] vs_addr,
   input  logic [NoVs-1:0]              vs_read,
   output logic                         hazard
);

   // Scalar register 0 is a hard zero unless tracking is enabled, so it never conflicts.
   localparam logic TRACK_X0 = (TrackX0 != 0) ? 1'b1 : 1'b0;

   logic hit;

   // OR together RAW (per source) and WAW hits; gated by the entry being valid.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NoRs; i++) begin
         hit = hit | (e_rd_wr & rs_read[i]
                      & (rs_addr[i*RegAddrWidth +: RegAddrWidth] == e_rd_addr)
                      & (TRACK_X0 | (e_rd_addr != {RegAddrWidth{1'b0}})));
      end
      for (int j = 0; j < NoVs; j++) begin
         hit = hit | (e_vd_wr & vs_read[j]
                      & (vs_addr[j*VecAddrWidth +: VecAddrWidth] == e_vd_addr));
      end
      hit = hit | (e_rd_wr & rd_clob & (rd_addr == e_rd_addr)
                   & (TRACK_X0 | (e_rd_addr != {RegAddrWidth{1'b0}})));
      hit = hit | (e_vd_wr & vd_clob & (vd_addr == e_vd_addr));
      hazard = e_valid & hit;
   end

endmodule

// File: rtl/xadac_scoreboard.sv
// In-flight instruction tracker: in-order ID allocation, out-of-order retire,
// decode stall on RAW/WAW hazards against outstanding destinations.
module xadac_scoreboard
   import xadac_scoreboard_pkg::*;
#(
   parameter int unsigned NoRs         = NO_RS_DEF,
   parameter int unsigned NoVs         = NO_VS_DEF,
   parameter int unsigned IdWidth      = ID_WIDTH_DEF,
   parameter int unsigned RegAddrWidth = REG_ADDR_WIDTH_DEF,
   parameter int unsigned VecAddrWidth = VEC_ADDR_WIDTH_DEF,
   parameter int unsigned TrackX0      = 0
) (
   input logic         clk_i,
   input logic         rst_ni,
   xadac_scoreboard_if.slave bus
);

   localparam int unsigned SbLen = sb_len(IdWidth);

   typedef struct packed {
      logic                    valid;
      logic [RegAddrWidth-1:0] rd_addr;
      logic                    rd_wr;
      logic [VecAddrWidth-1:0] vd_addr;
      logic                    vd_wr;
   } sb_entry_t;

   sb_entry_t          entries [SbLen];
   logic [IdWidth-1:0] tail;
   logic [IdWidth:0]   count;
   logic               spurious;
   logic [SbLen-1:0]   hits;
   logic               hazard;
   logic               full;
   logic               ready;
   logic               fire;
   logic               retire_ok;

   for (genvar g = 0; g < SbLen; g++) begin : g_match
      xadac_scoreboard_match #(
         .NoRs(NoRs), .NoVs(NoVs), .RegAddrWidth(RegAddrWidth),
         .VecAddrWidth(VecAddrWidth), .TrackX0(TrackX0)
      ) u_match (
         .e_valid   (entries[g].valid),
         .e_rd_addr (entries[g].rd_addr),
         .e_rd_wr   (entries[g].rd_wr),
         .e_vd_addr (entries[g].vd_addr),
         .e_vd_wr   (entries[g].vd_wr),
         .rd_addr   (bus.dec_rd_addr_i),
         .rd_clob   (bus.dec_rd_clob_i),
         .vd_addr   (bus.dec_vd_addr_i),
         .vd_clob   (bus.dec_vd_clob_i),
         .rs_addr   (bus.dec_rs_addr_i),
         .rs_read   (bus.dec_rs_read_i),
         .vs_addr   (bus.dec_vs_addr_i),
         .vs_read   (bus.dec_vs_read_i),
         .hazard    (hits[g])
      );
   end

   // Hazards look only at registered entries; a retire this cycle frees nothing until next cycle.
   assign hazard    = |hits;
   assign full      = entries[tail].valid;
   assign ready     = rst_ni & ~bus.flush_i & ~full & ~hazard;
   assign fire      = bus.dec_valid_i & ready;
   assign retire_ok = bus.rsp_valid_i & entries[bus.rsp_id_i].valid;

   assign bus.dec_ready_o = ready;
   assign bus.dec_id_o    = tail;
   assign bus.count_o     = count;
   assign bus.full_o      = full;
   assign bus.spurious_o  = spurious;

   // Entry array, tail pointer, occupancy count and spurious-retire flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < SbLen; i++) begin
            entries[i] <= '0;
         end
         tail     <= {IdWidth{1'b0}};
         count    <= {(IdWidth+1){1'b0}};
         spurious <= 1'b0;
      end else if (bus.flush_i) begin
         for (int i = 0; i < SbLen; i++) begin
            entries[i].valid <= 1'b0;
         end
         tail     <= {IdWidth{1'b0}};
         count    <= {(IdWidth+1){1'b0}};
         spurious <= 1'b0;
      end else begin
         spurious <= bus.rsp_valid_i & ~entries[bus.rsp_id_i].valid;
         // Retire and allocate never hit the same slot: allocation requires a free tail.
         if (retire_ok) begin
            entries[bus.rsp_id_i].valid <= 1'b0;
         end
         if (fire) begin
            entries[tail] <= '{valid:   1'b1,
                               rd_addr: bus.dec_rd_addr_i,
                               rd_wr:   bus.dec_rd_clob_i,
                               vd_addr: bus.dec_vd_addr_i,
                               vd_wr:   bus.dec_vd_clob_i};
            tail <= tail + IdWidth'(1);
         end
         count <= count + {{IdWidth{1'b0}}, fire} - {{IdWidth{1'b0}}, retire_ok};
      end
   end

endmodule

// File: tb/tb_xadac_scoreboard.sv
// Self-checking bench for xadac_scoreboard: directed scenarios plus randomized
// traffic compared against a behavioural model of the in-flight table.
module tb_xadac_scoreboard;

   localparam int NRS = 2;
   localparam int NVS = 3;
   localparam int IDW = 3;
   localparam int RAW = 5;
   localparam int VAW = 5;
   localparam int SB  = 8;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   xadac_scoreboard_if #(.NoRs(NRS), .NoVs(NVS), .IdWidth(IDW), .RegAddrWidth(RAW), .VecAddrWidth(VAW)) bus0 ();
   xadac_scoreboard_if #(.NoRs(NRS), .NoVs(NVS), .IdWidth(IDW), .RegAddrWidth(RAW), .VecAddrWidth(VAW)) bus1 ();

   xadac_scoreboard #(.NoRs(NRS), .NoVs(NVS), .IdWidth(IDW), .RegAddrWidth(RAW),
                      .VecAddrWidth(VAW), .TrackX0(0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
   xadac_scoreboard #(.NoRs(NRS), .NoVs(NVS), .IdWidth(IDW), .RegAddrWidth(RAW),
                      .VecAddrWidth(VAW), .TrackX0(1)) dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(bus1));

   // ---------------- behavioural model of dut0 (TrackX0 = 0) ----------------
   bit           m_v   [SB];
   logic [4:0]   m_rd  [SB];
   bit           m_rdw [SB];
   logic [4:0]   m_vd  [SB];
   bit           m_vdw [SB];
   int           m_tail;
   bit           m_spur;

   function automatic bit m_hazard();
      bit h = 1'b0;
      for (int e = 0; e < SB; e++) begin
         if (m_v[e]) begin
            for (int i = 0; i < NRS; i++)
               if (m_rdw[e] && bus0.dec_rs_read_i[i] && bus0.dec_rs_addr_i[i*RAW +: RAW] == m_rd[e] && m_rd[e] != 5'd0) h = 1'b1;
            for (int j = 0; j < NVS; j++)
               if (m_vdw[e] && bus0.dec_vs_read_i[j] && bus0.dec_vs_addr_i[j*VAW +: VAW] == m_vd[e]) h = 1'b1;
            if (m_rdw[e] && bus0.dec_rd_clob_i && bus0.dec_rd_addr_i == m_rd[e] && m_rd[e] != 5'd0) h = 1'b1;
            if (m_vdw[e] && bus0.dec_vd_clob_i && bus0.dec_vd_addr_i == m_vd[e]) h = 1'b1;
         end
      end
      return h;
   endfunction

   function automatic bit m_ready();
      return rst_n && !bus0.flush_i && !m_v[m_tail] && !m_hazard();
   endfunction

   function automatic int m_count();
      int c = 0;
      for (int e = 0; e < SB; e++) c += int'(m_v[e]);
      return c;
   endfunction

   task automatic model_reset();
      for (int e = 0; e < SB; e++) m_v[e] = 1'b0;
      m_tail = 0;
      m_spur = 1'b0;
   endtask

   // Advance one clock; the model applies the same cycle's inputs.
   task automatic tick();
      bit fire;
      fire = bus0.dec_valid_i && m_ready();
      @(posedge clk);
      if (bus0.flush_i) begin
         model_reset();
      end else begin
         m_spur = bus0.rsp_valid_i && !m_v[bus0.rsp_id_i];
         if (bus0.rsp_valid_i) m_v[bus0.rsp_id_i] = 1'b0;
         if (fire) begin
            m_v[m_tail]   = 1'b1;
            m_rd[m_tail]  = bus0.dec_rd_addr_i;
            m_rdw[m_tail] = bus0.dec_rd_clob_i;
            m_vd[m_tail]  = bus0.dec_vd_addr_i;
            m_vdw[m_tail] = bus0.dec_vd_clob_i;
            m_tail = (m_tail + 1) % SB;
         end
      end
      #1;
   endtask

   task automatic idle();
      bus0.flush_i = 1'b0; bus0.dec_valid_i = 1'b0; bus0.dec_rd_addr_i = '0; bus0.dec_rd_clob_i = 1'b0;
      bus0.dec_vd_addr_i = '0; bus0.dec_vd_clob_i = 1'b0; bus0.dec_rs_addr_i = '0; bus0.dec_rs_read_i = '0;
      bus0.dec_vs_addr_i = '0; bus0.dec_vs_read_i = '0; bus0.rsp_valid_i = 1'b0; bus0.rsp_id_i = '0;
      bus1.flush_i = 1'b0; bus1.dec_valid_i = 1'b0; bus1.dec_rd_addr_i = '0; bus1.dec_rd_clob_i = 1'b0;
      bus1.dec_vd_addr_i = '0; bus1.dec_vd_clob_i = 1'b0; bus1.dec_rs_addr_i = '0; bus1.dec_rs_read_i = '0;
      bus1.dec_vs_addr_i = '0; bus1.dec_vs_read_i = '0; bus1.rsp_valid_i = 1'b0; bus1.rsp_id_i = '0;
   endtask

   task automatic do_flush();
      idle();
      bus0.flush_i = 1'b1;
      bus1.flush_i = 1'b1;
      tick();
      idle();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      bus0.dec_valid_i = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus0.dec_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", bus0.dec_ready_o); end
      checks++; if (bus0.count_o !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", bus0.count_o); end
      checks++; if (bus0.full_o !== 1'b0) begin failures++; $display("FAIL reset_full got=%b want=0", bus0.full_o); end
      checks++; if (bus0.spurious_o !== 1'b0) begin failures++; $display("FAIL reset_spurious got=%b want=0", bus0.spurious_o); end
      checks++; if (bus0.dec_id_o !== 3'd0) begin failures++; $display("FAIL reset_id got=%0d want=0", bus0.dec_id_o); end
      model_reset();
      idle();
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (bus0.dec_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b want=1", bus0.dec_ready_o); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < SB; i++) begin
         bus0.dec_valid_i = 1'b1; bus0.dec_rd_clob_i = 1'b1; bus0.dec_rd_addr_i = 5'(i + 1);
         #2;
         checks++; if (bus0.dec_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready[%0d] got=%b want=1", i, bus0.dec_ready_o); end
         checks++; if (bus0.dec_id_o !== 3'(i)) begin failures++; $display("FAIL fill_id[%0d] got=%0d want=%0d", i, bus0.dec_id_o, i); end
         tick();
      end
      bus0.dec_rd_addr_i = 5'd9;
      #2;
      checks++; if (bus0.count_o !== 4'd8) begin failures++; $display("FAIL fill_count got=%0d want=8", bus0.count_o); end
      checks++; if (bus0.full_o !== 1'b1) begin failures++; $display("FAIL fill_full got=%b want=1", bus0.full_o); end
      checks++; if (bus0.dec_ready_o !== 1'b0) begin failures++; $display("FAIL fill_9th_ready got=%b want=0", bus0.dec_ready_o); end
      tick();
      do_flush();
   endtask

   task automatic test_raw();
      bus0.dec_valid_i = 1'b1; bus0.dec_rd_clob_i = 1'b1; bus0.dec_rd_addr_i = 5'd5;
      #2;
      checks++; if (bus0.dec_id_o !== 3'd0) begin failures++; $display("FAIL raw_first_id got=%0d want=0", bus0.dec_id_o); end
      tick();
      bus0.dec_rd_clob_i = 1'b0; bus0.dec_rd_addr_i = 5'd0;
      bus0.dec_rs_addr_i[0 +: RAW] = 5'd5; bus0.dec_rs_read_i = 2'b01;
      #2;
      checks++; if (bus0.dec_ready_o !== 1'b0) begin failures++; $display("FAIL raw_stall got=%b want=0", bus0.dec_ready_o); end
      tick();
      bus0.rsp_valid_i = 1'b1; bus0.rsp_id_i = 3'd0;
      #2;
      checks++; if (bus0.dec_ready_o !== 1'b0) begin failures++; $display("FAIL raw_no_bypass got=%b want=0", bus0.dec_ready_o); end
      tick();
      bus0.rsp_valid_i = 1'b0;
      #2;
      checks++; if (bus0.dec_ready_o !== 1'b1) begin failures++; $display("FAIL raw_release got=%b want=1", bus0.dec_ready_o); end
      checks++; if (bus0.dec_id_o !== 3'd1) begin failures++; $display("FAIL raw_release_id got=%0d want=1", bus0.dec_id_o); end
      tick();
      idle();
      #2;
      checks++; if (bus0.count_o !== 4'd1) begin failures++; $display("FAIL raw_count got=%0d want=1", bus0.count_o); end
      do_flush();
   endtask

   task automatic test_waw_vec();
      bus0.dec_valid_i = 1'b1; bus0.dec_vd_clob_i = 1'b1; bus0.dec_vd_addr_i = 5'd3;
      tick();
      #2;
      checks++; if (bus0.dec_ready_o !== 1'b0) begin failures++; $display("FAIL vec_waw_stall got=%b want=0", bus0.dec_ready_o); end
      bus0.dec_vd_clob_i = 1'b0; bus0.dec_vd_addr_i = 5'd0;
      bus0.dec_vs_addr_i[2*VAW +: VAW] = 5'd3; bus0.dec_vs_read_i = 3'b100;
      #2;
      checks++; if (bus0.dec_ready_o !== 1'b0) begin failures++; $display("FAIL vec_raw_stall got=%b want=0", bus0.dec_ready_o); end
      bus0.dec_vs_read_i = 3'b011;
      #2;
      checks++; if (bus0.dec_ready_o !== 1'b1) begin failures++; $display("FAIL vec_unread_accept got=%b want=1", bus0.dec_ready_o); end
      checks++; if (bus0.dec_id_o !== 3'd1) begin failures++; $display("FAIL vec_unread_id got=%0d want=1", bus0.dec_id_o); end
      tick();
      do_flush();
   endtask

   task automatic test_x0();
      bus0.dec_valid_i = 1'b1; bus0.dec_rd_clob_i = 1'b1; bus0.dec_rd_addr_i = 5'd0;
      bus1.dec_valid_i = 1'b1; bus1.dec_rd_clob_i = 1'b1; bus1.dec_rd_addr_i = 5'd0;
      #2;
      checks++; if (bus1.dec_ready_o !== 1'b1) begin failures++; $display("FAIL x0_t1_first got=%b want=1", bus1.dec_ready_o); end
      tick();
      bus0.dec_rd_clob_i = 1'b0; bus0.dec_rs_addr_i = '0; bus0.dec_rs_read_i = 2'b01;
      bus1.dec_rd_clob_i = 1'b0; bus1.dec_rs_addr_i = '0; bus1.dec_rs_read_i = 2'b01;
      #2;
      checks++; if (bus0.dec_ready_o !== 1'b1) begin failures++; $display("FAIL x0_ignored got=%b want=1", bus0.dec_ready_o); end
      checks++; if (bus1.dec_ready_o !== 1'b0) begin failures++; $display("FAIL x0_tracked got=%b want=0", bus1.dec_ready_o); end
      checks++; if (bus1.count_o !== 4'd1) begin failures++; $display("FAIL x0_t1_count got=%0d want=1", bus1.count_o); end
      tick();
      do_flush();
   endtask

   task automatic test_spurious();
      for (int i = 0; i < 3; i++) begin
         bus0.dec_valid_i = 1'b1;
         tick();
      end
      idle();
      bus0.rsp_valid_i = 1'b1; bus0.rsp_id_i = 3'd6;
      #2;
      checks++; if (bus0.count_o !== 4'd3) begin failures++; $display("FAIL spur_pre_count got=%0d want=3", bus0.count_o); end
      tick();
      bus0.rsp_id_i = 3'd1;
      #2;
      checks++; if (bus0.spurious_o !== 1'b1) begin failures++; $display("FAIL spur_pulse got=%b want=1", bus0.spurious_o); end
      checks++; if (bus0.count_o !== 4'd3) begin failures++; $display("FAIL spur_count got=%0d want=3", bus0.count_o); end
      tick();
      idle();
      #2;
      checks++; if (bus0.spurious_o !== 1'b0) begin failures++; $display("FAIL spur_valid_retire got=%b want=0", bus0.spurious_o); end
      checks++; if (bus0.count_o !== 4'd2) begin failures++; $display("FAIL spur_retire_count got=%0d want=2", bus0.count_o); end
      do_flush();
   endtask

   task automatic test_flush();
      for (int i = 0; i < 5; i++) begin
         bus0.dec_valid_i = 1'b1;
         tick();
      end
      bus0.flush_i = 1'b1; bus0.rsp_valid_i = 1'b1; bus0.rsp_id_i = 3'd7;
      #2;
      checks++; if (bus0.dec_ready_o !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b want=0", bus0.dec_ready_o); end
      tick();
      idle();
      #2;
      checks++; if (bus0.count_o !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d want=0", bus0.count_o); end
      checks++; if (bus0.spurious_o !== 1'b0) begin failures++; $display("FAIL flush_spurious got=%b want=0", bus0.spurious_o); end
      bus0.dec_valid_i = 1'b1;
      #2;
      checks++; if (bus0.dec_ready_o !== 1'b1 || bus0.dec_id_o !== 3'd0) begin failures++;
         $display("FAIL flush_next_alloc got ready=%b id=%0d want ready=1 id=0", bus0.dec_ready_o, bus0.dec_id_o); end
      tick();
      do_flush();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 3; i++) begin
         bus0.dec_valid_i = 1'b1;
         tick();
      end
      idle();
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus0.count_o !== 4'd0 || bus0.full_o !== 1'b0 || bus0.dec_ready_o !== 1'b0 || bus0.dec_id_o !== 3'd0) begin
         failures++; $display("FAIL async_reset got count=%0d full=%b ready=%b id=%0d want 0/0/0/0",
                              bus0.count_o, bus0.full_o, bus0.dec_ready_o, bus0.dec_id_o); end
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         bus0.flush_i       = ($urandom_range(0, 39) == 0);
         bus0.dec_valid_i   = ($urandom_range(0, 9) < 7);
         bus0.dec_rd_addr_i = 5'($urandom_range(0, 3));
         bus0.dec_rd_clob_i = 1'($urandom_range(0, 1));
         bus0.dec_vd_addr_i = 5'($urandom_range(0, 3));
         bus0.dec_vd_clob_i = 1'($urandom_range(0, 1));
         for (int i = 0; i < NRS; i++) bus0.dec_rs_addr_i[i*RAW +: RAW] = 5'($urandom_range(0, 7));
         for (int j = 0; j < NVS; j++) bus0.dec_vs_addr_i[j*VAW +: VAW] = 5'($urandom_range(0, 7));
         bus0.dec_rs_read_i = 2'($urandom_range(0, 3));
         bus0.dec_vs_read_i = 3'($urandom_range(0, 7));
         bus0.rsp_valid_i   = 1'($urandom_range(0, 1));
         bus0.rsp_id_i      = 3'($urandom_range(0, 7));
         #2;
         checks++; if (bus0.dec_ready_o !== m_ready()) begin failures++; $display("FAIL rnd_ready[%0d] got=%b want=%b", c, bus0.dec_ready_o, m_ready()); end
         checks++; if (bus0.dec_id_o !== 3'(m_tail)) begin failures++; $display("FAIL rnd_id[%0d] got=%0d want=%0d", c, bus0.dec_id_o, m_tail); end
         checks++; if (bus0.count_o !== 4'(m_count())) begin failures++; $display("FAIL rnd_count[%0d] got=%0d want=%0d", c, bus0.count_o, m_count()); end
         checks++; if (bus0.full_o !== m_v[m_tail]) begin failures++; $display("FAIL rnd_full[%0d] got=%b want=%b", c, bus0.full_o, m_v[m_tail]); end
         checks++; if (bus0.spurious_o !== m_spur) begin failures++; $display("FAIL rnd_spurious[%0d] got=%b want=%b", c, bus0.spurious_o, m_spur); end
         tick();
      end
      do_flush();
   endtask

   initial begin
      test_reset();
      test_fill();
      test_raw();
      test_waw_vec();
      test_x0();
      test_spurious();
      test_flush();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
